// File: rtl/cpu_pkg.sv
// Shared processor types: fetch FSM states, extender selects,
// instruction class codes and datapath widths.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int IMM_W   = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DRAIN = 2'b10
  } fetch_state_e;

  typedef enum logic [1:0] {
    EXT_ZERO   = 2'b00,
    EXT_SIGN   = 2'b01,
    EXT_BRANCH = 2'b10
  } ext_sel_e;

  localparam logic [3:0] CLS_LOGI = 4'h1;
  localparam logic [3:0] CLS_ARI  = 4'h2;
  localparam logic [3:0] CLS_BR   = 4'h3;
  localparam logic [3:0] CLS_MEM  = 4'h4;

endpackage

// File: rtl/imm_predecode.sv
// Immediate pre-decode: picks the 20-bit immediate field and the
// extender select from the instruction class; shared with decode.
module imm_predecode
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [IMM_W-1:0]   imm,
  output logic [1:0]         ext_sel
);

  logic unused_mid;

  assign imm        = instr[IMM_W-1:0];
  assign unused_mid = ^instr[27:20];

  always_comb begin
    ext_sel = EXT_ZERO;
    unique case (instr[31:28])
      CLS_LOGI:         ext_sel = EXT_ZERO;
      CLS_ARI, CLS_MEM: ext_sel = EXT_SIGN;
      CLS_BR:           ext_sel = EXT_BRANCH;
      default:          ext_sel = EXT_ZERO;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch FSM with IF/ID register, stall and redirect.
// Define FETCH_PERF_EN to enable the saturating perf counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  input  logic             imem_rvalid_i,
  input  logic [31:0]      imem_rdata_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  output logic             id_valid_o,
  input  logic             id_ready_i,
  output logic [31:0]      instr_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic [IMM_W-1:0] imm_o,
  output logic [1:0]       ext_sel_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  drain_addr;
  logic [31:0]  instr_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc4_q;
  logic         valid_q;
  logic         pending;
  logic         can_load;
  logic         req;
  logic         take;
  logic         transfer;
  logic         unused_rpc;

  assign can_load   = !valid_q || id_ready_i;
  assign transfer   = valid_q && id_ready_i;
  assign unused_rpc = ^redirect_pc_i[1:0];

  // An issued request stays up until answered, even if decode stalls.
  always_comb begin
    req = 1'b0;
    unique case (state)
      FETCH:   req = pending || can_load;
      DRAIN:   req = 1'b1;
      default: req = 1'b0;
    endcase
  end

  always_comb begin
    imem_addr_o = 32'h0;
    unique case (state)
      FETCH:   imem_addr_o = pc;
      DRAIN:   imem_addr_o = drain_addr;
      default: imem_addr_o = 32'h0;
    endcase
  end

  assign take = (state == FETCH) && req &&
                imem_rvalid_i && !redirect_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      drain_addr <= 32'h0;
      pending    <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= 32'h0;
      pc_q       <= 32'h0;
      pc4_q      <= 32'h0;
    end else begin
      unique case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (redirect_i && req && !imem_rvalid_i) begin
            state      <= DRAIN;
            drain_addr <= pc;
          end
          pending <= req && !imem_rvalid_i && !redirect_i;
        end
        DRAIN: begin
          pending <= 1'b0;
          if (imem_rvalid_i) state <= FETCH;
        end
        default: state <= IDLE;
      endcase
      if (state != IDLE && redirect_i) begin
        pc      <= {redirect_pc_i[31:2], 2'b00};
        valid_q <= 1'b0;
      end else if (take) begin
        pc      <= pc + 32'd4;
        valid_q <= 1'b1;
        instr_q <= imem_rdata_i;
        pc_q    <= pc;
        pc4_q   <= pc + 32'd4;
      end else if (transfer) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign imem_req_o = req;
  assign id_valid_o = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc4_q;

  imm_predecode u_predecode (
    .instr   (instr_q),
    .imm     (imm_o),
    .ext_sel (ext_sel_o)
  );

`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             stall;

  assign stall = valid_q && !id_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (transfer && !(&fetch_cnt))
        fetch_cnt <= fetch_cnt + CNT_W'(1);
      if (stall && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign fetch_cnt_o = fetch_cnt;
  assign stall_cnt_o = stall_cnt;
`else
  assign fetch_cnt_o = '0;
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic
// against a transaction-level fetch/deliver model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [19:0] imm;
  logic [1:0]  ext_sel;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  logic        req2;
  logic [31:0] addr2;
  logic        rv2 = 1'b0;
  logic [31:0] rd2 = 32'h0;
  logic        redir2 = 1'b0;
  logic [31:0] rpc2 = 32'h0;
  logic        rdy2 = 1'b1;
  logic        valid2;
  logic [31:0] instr2;
  logic [31:0] pc_2;
  logic [31:0] pc4_2;
  logic [19:0] imm2;
  logic [1:0]  ext2;
  logic [31:0] fcnt2;
  logic [31:0] scnt2;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .id_valid_o(id_valid), .id_ready_i(id_ready),
    .instr_o(instr), .pc_o(pc), .pc_plus4_o(pc4),
    .imm_o(imm), .ext_sel_o(ext_sel),
    .fetch_cnt_o(fetch_cnt), .stall_cnt_o(stall_cnt)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(32)) dut2 (
    .clk_i(clk), .rst_ni(rst_ni),
    .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_rvalid_i(rv2), .imem_rdata_i(rd2),
    .redirect_i(redir2), .redirect_pc_i(rpc2),
    .id_valid_o(valid2), .id_ready_i(rdy2),
    .instr_o(instr2), .pc_o(pc_2), .pc_plus4_o(pc4_2),
    .imm_o(imm2), .ext_sel_o(ext2),
    .fetch_cnt_o(fcnt2), .stall_cnt_o(scnt2)
  );

  // zero-wait memory for the second instance
  always begin
    @(negedge clk);
    #1;
    rv2 = req2;
    rd2 = addr2;
  end

  int          cmp_n = 0;
  int          bad_n = 0;
  bit          exp_valid;
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic [31:0] exp_fetch;
  logic [31:0] prev_addr;
  bit          prev_req;
  bit          prev_rvalid;
  bit          aborted;
  bit          idle_cyc;
  int unsigned fcnt;
  int unsigned scnt;
  int          wait_n;
  int          lat_fix = 0;
  int          mem_mode = 0;
  logic [31:0] mem_const = 32'h0;
  bit          late_rv = 1'b0;
  bit          last_req;
  bit          last_cont;
  logic [31:0] last_addr;
  int          xfers = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] want);
    cmp_n++;
    if (act !== want) begin
      bad_n++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (mem_mode)
      0:       return a;
      1:       return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
      2:       return mem_const;
      default: return a[2] ? 32'h1008_0000 : 32'h2008_0000;
    endcase
  endfunction

  function automatic logic [1:0] ref_ext(input logic [31:0] w);
    case (w[31:28])
      4'h2, 4'h4: return 2'b01;
      4'h3:       return 2'b10;
      default:    return 2'b00;
    endcase
  endfunction

  task automatic check_regs();
    chk("id_valid", {31'h0, id_valid}, {31'h0, exp_valid});
    if (exp_valid) begin
      chk("pc_o", pc, exp_pc);
      chk("instr_o", instr, exp_instr);
      chk("pc_plus4", pc4, exp_pc + 32'd4);
      chk("imm_o", {12'h0, imm}, {12'h0, exp_instr[19:0]});
      chk("ext_sel", {30'h0, ext_sel},
          {30'h0, ref_ext(exp_instr)});
    end
`ifdef FETCH_PERF_EN
    chk("fetch_cnt", fetch_cnt, fcnt);
    chk("stall_cnt", stall_cnt, scnt);
`else
    chk("fetch_cnt0", fetch_cnt, 32'h0);
    chk("stall_cnt0", stall_cnt, 32'h0);
`endif
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit rdy, input bit rd,
                      input logic [31:0] rpc);
    bit          cont;
    bit          exp_req;
    bit          rv;
    logic [31:0] a;
    logic [31:0] d;
    check_regs();
    id_ready    = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    imem_rvalid = 1'b0;
    #1;
    cont    = prev_req && !prev_rvalid;
    exp_req = !idle_cyc && (cont || !exp_valid || rdy);
    chk("req", {31'h0, imem_req}, {31'h0, exp_req});
    a = imem_addr;
    if (imem_req) begin
      if (cont) chk("addr_hold", a, prev_addr);
      else begin
        chk("addr_fetch", a, exp_fetch);
        wait_n = (lat_fix >= 0) ? lat_fix
                                : int'($urandom_range(0, 3));
      end
    end
    rv = imem_req && (wait_n == 0);
    d  = mem_word(a);
    if (idle_cyc && late_rv) begin
      rv = 1'b1;
      d  = 32'h3ABC_DEF0;
    end
    imem_rvalid = rv;
    imem_rdata  = d;
    #1;
    if (exp_valid && rdy) begin
      fcnt++;
      xfers++;
    end
    if (exp_valid && !rdy) scnt++;
    if (idle_cyc) begin
    end else if (rd) begin
      exp_valid = 1'b0;
      exp_fetch = {rpc[31:2], 2'b00};
      aborted   = imem_req && !rv;
    end else if (imem_req && rv) begin
      if (aborted) aborted = 1'b0;
      else begin
        exp_valid = 1'b1;
        exp_pc    = a;
        exp_instr = d;
        exp_fetch = a + 32'd4;
      end
    end else if (exp_valid && rdy) begin
      exp_valid = 1'b0;
    end
    if (imem_req && !rv) wait_n--;
    prev_req    = imem_req;
    prev_rvalid = rv;
    prev_addr   = a;
    last_req    = imem_req;
    last_cont   = cont;
    last_addr   = a;
    idle_cyc    = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    id_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    #1;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc4, 32'h0);
    chk("rst_imm", {12'h0, imm}, 32'h0);
    chk("rst_ext", {30'h0, ext_sel}, 32'h0);
    chk("rst_fcnt", fetch_cnt, 32'h0);
    chk("rst_scnt", stall_cnt, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_ni      = 1'b1;
    exp_valid   = 1'b0;
    exp_fetch   = 32'h0;
    prev_req    = 1'b0;
    prev_rvalid = 1'b0;
    aborted     = 1'b0;
    idle_cyc    = 1'b1;
    fcnt        = 0;
    scnt        = 0;
    wait_n      = 0;
  endtask

  initial begin
    logic [31:0] snap;
    bit          found;
    int          x0;
    rst_ni = 1'b0;
    @(negedge clk);
    do_reset();

    // zero-wait, data = address, decode always ready
    mem_mode = 0;
    lat_fix  = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) chk("t1_valid_c2", {31'h0, id_valid}, 32'h0);
      if (i >= 2) begin
        chk("t1_valid", {31'h0, id_valid}, 32'h1);
        chk("t1_pc", pc, 32'(i - 2) * 32'd4);
      end
      if (i == 2) chk("t5_pc_a", pc_2, 32'hFFFF_FFF8);
      if (i == 3) begin
        chk("t5_pc_b", pc_2, 32'hFFFF_FFFC);
        chk("t5_pc4_wrap", pc4_2, 32'h0);
      end
      if (i == 4) chk("t5_pc_c", pc_2, 32'h0);
      step(1'b1, 1'b0, 32'h0);
    end

    // stall with a branch-class instruction held
    step(1'b0, 1'b1, 32'h40);
    mem_mode  = 2;
    mem_const = 32'h3000_0010;
    step(1'b0, 1'b0, 32'h0);
    chk("t2_valid", {31'h0, id_valid}, 32'h1);
    chk("t2_ext", {30'h0, ext_sel}, 32'h2);
    chk("t2_imm", {12'h0, imm}, 32'h0_0010);
    snap = stall_cnt;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 32'h0);
      chk("t2_noreq", {31'h0, last_req}, 32'h0);
    end
    chk("t2_instr", instr, 32'h3000_0010);
    chk("t2_pc", pc, 32'h40);
`ifdef FETCH_PERF_EN
    chk("t2_stall5", stall_cnt, snap + 32'd5);
`else
    chk("t2_stall0", stall_cnt, snap);
`endif

    // latency 3, redirect while the request is outstanding
    mem_mode = 1;
    lat_fix  = 3;
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h103);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      chk("t3_drain_valid", {31'h0, id_valid}, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      found = last_req && !last_cont;
    end
    chk("t3_found", {31'h0, found}, 32'h1);
    chk("t3_addr", last_addr, 32'h100);

    // redirect coincident with rvalid while decode stalls
    lat_fix = 0;
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h200);
    step(1'b0, 1'b1, 32'h300);
    chk("t4_rv_req", {31'h0, last_req}, 32'h1);
    chk("t4_rv_addr", last_addr, 32'h200);
    chk("t4_flushed", {31'h0, id_valid}, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("t4_next_addr", last_addr, 32'h300);
    chk("t4_pc", pc, 32'h300);

    // sign-extend then zero-extend classes
    mem_mode = 3;
    step(1'b1, 1'b1, 32'h400);
    step(1'b1, 1'b0, 32'h0);
    chk("t6_ext_a", {30'h0, ext_sel}, 32'h1);
    chk("t6_imm_a", {12'h0, imm}, 32'h8_0000);
    step(1'b1, 1'b0, 32'h0);
    chk("t6_ext_b", {30'h0, ext_sel}, 32'h0);
    chk("t6_imm_b", {12'h0, imm}, 32'h8_0000);

    // reset mid-fetch, then a late response in IDLE
    mem_mode = 1;
    lat_fix  = 3;
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    do_reset();
    late_rv = 1'b1;
    step(1'b1, 1'b0, 32'h0);
    late_rv = 1'b0;
    chk("late_rvalid", {31'h0, id_valid}, 32'h0);

    // random traffic
    lat_fix = -1;
    x0      = xfers;
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0)
          ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
          : $urandom;
      step($urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 6, rpc);
    end
    chk("throughput", {31'h0, (xfers - x0) > 300}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_n, bad_n);
    $finish;
  end

endmodule
